// File: rtl/tpu_pkg.sv
// Shared types for the matrix-unit datapath and its sequencers.
// Lane data is signed 16-bit; the feed sequencer FSM encoding lives here too.
package tpu_pkg;

    localparam int DATA_W = 16;

    typedef logic signed [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } feed_state_e;

endpackage

// File: rtl/mmu_feed_sequencer.sv
// Streams K activation vectors from the buffer into the skew buffer, waits out array latency, pulses done.
// Optional FEED_STALL_EN adds a stall input that holds issue (and inserts a feed bubble) while in FEED.
module mmu_feed_sequencer
    import tpu_pkg::*;
#(
    parameter int N         = 2,
    parameter int ADDR_W    = 8,
    parameter int CNT_W     = 8,
    parameter int DRAIN_LAT = 2 * N
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [CNT_W-1:0]      num_vecs,
`ifdef FEED_STALL_EN
    input  logic                  stall,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_W-1:0]     mem_rd_addr,
    input  logic [N*DATA_W-1:0]   mem_rd_data,
    output logic [N*DATA_W-1:0]   feed_data,
    output logic                  feed_valid
);

    localparam int DRN_W = (DRAIN_LAT < 1) ? 1 : $clog2(DRAIN_LAT + 1);

    feed_state_e        state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [DRN_W-1:0]   drn_q, drn_d;
    logic               fv_q;
    logic               rd_en;
    logic               hold_w;

`ifdef FEED_STALL_EN
    assign hold_w = stall;
`else
    assign hold_w = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            drn_q   <= '0;
            fv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            drn_q   <= drn_d;
            fv_q    <= rd_en;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        drn_d   = drn_q;
        rd_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    rem_d   = num_vecs;
                    state_d = (num_vecs != '0) ? FEED : DONE;
                end
            end
            FEED: begin
                if (!hold_w) begin
                    rd_en  = 1'b1;
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    // The last read's data lands during the first DRAIN cycle.
                    if (rem_q == CNT_W'(1)) begin
                        state_d = DRAIN;
                        drn_d   = DRN_W'(DRAIN_LAT);
                    end
                end
            end
            DRAIN: begin
                if (drn_q == '0) state_d = DONE;
                else             drn_d   = drn_q - 1'b1;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q == FEED) || (state_q == DRAIN);
    assign done        = (state_q == DONE);
    assign mem_rd_en   = rd_en;
    assign mem_rd_addr = rd_en ? addr_q : '0;
    assign feed_valid  = fv_q;
    assign feed_data   = fv_q ? mem_rd_data : '0;

endmodule

// File: tb/tb_mmu_feed_sequencer.sv
// Scoreboarded random/directed bench for mmu_feed_sequencer (N=4, DRAIN_LAT=8).
// Stall stimulus is exercised when FEED_STALL_EN is defined.
module tb_mmu_feed_sequencer;

    localparam int N   = 4;
    localparam int DL  = 8;
    localparam int AW  = 8;
    localparam int CW  = 8;
    localparam int DW  = N * 16;
    localparam int PATLEN = 8192;

    typedef struct {
        int            cyc;
        logic [DW-1:0] val;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] num_vecs;
    logic          stall;
    logic          busy, done, mem_rd_en, feed_valid;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic [DW-1:0] feed_data;

    logic [DW-1:0] mem [256];
    bit            stall_pat [PATLEN];
    ev_t           rd_q[$], fd_q[$], dn_q[$];
    int            busy_lo = 1, busy_hi = 0;
    int            cyc = 0;
    int            checks = 0, errors = 0;

    mmu_feed_sequencer #(.N(N), .ADDR_W(AW), .CNT_W(CW), .DRAIN_LAT(DL)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_vecs(num_vecs),
`ifdef FEED_STALL_EN
        .stall(stall),
`endif
        .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .feed_data(feed_data), .feed_valid(feed_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: a pass is a list of issue cycles (non-stalled FEED cycles), then fixed latencies.
    function automatic int model_pass(input int s, input logic [AW-1:0] b, input int k);
        int t;
        logic [AW-1:0] a;
        if (k == 0) begin
            dn_q.push_back('{s + 1, '0});
            return s + 1;
        end
        t = s + 1;
        for (int i = 0; i < k; i++) begin
            while (t < PATLEN && stall_pat[t]) t++;
            a = b + AW'(i);
            rd_q.push_back('{t, DW'(a)});
            fd_q.push_back('{t + 1, mem[a]});
            t++;
        end
        busy_lo = s + 1;
        busy_hi = t + DL;
        dn_q.push_back('{t + 1 + DL, '0});
        return t + 1 + DL;
    endfunction

    // Activation SRAM: one-cycle read latency, junk on the bus when no read is returning.
    initial begin
        bit            p;
        logic [AW-1:0] a;
        mem_rd_data = '0;
        forever begin
            @(negedge clk);
            p = mem_rd_en;
            a = mem_rd_addr;
            @(posedge clk);
            #1;
            mem_rd_data = p ? mem[a] : {$urandom, $urandom};
        end
    end

    initial begin
        stall = 1'b0;
        forever begin
            @(posedge clk);
            #1;
`ifdef FEED_STALL_EN
            stall = (cyc < PATLEN) ? stall_pat[cyc] : 1'b0;
`endif
        end
    end

    always @(negedge clk) begin
        bit ex;
        if (!rst) begin
            while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
                errors++; $display("FAIL rd_missed cyc=%0d got none required addr=%h", rd_q[0].cyc, rd_q[0].val); void'(rd_q.pop_front());
            end
            while (fd_q.size() > 0 && fd_q[0].cyc < cyc) begin
                errors++; $display("FAIL feed_missed cyc=%0d got none required data=%h", fd_q[0].cyc, fd_q[0].val); void'(fd_q.pop_front());
            end
            while (dn_q.size() > 0 && dn_q[0].cyc < cyc) begin
                errors++; $display("FAIL done_missed cyc=%0d got none required pulse", dn_q[0].cyc); void'(dn_q.pop_front());
            end

            ex = rd_q.size() > 0 && rd_q[0].cyc == cyc;
            if (mem_rd_en || ex) begin
                checks++;
                if (!(mem_rd_en === 1'b1 && ex && DW'(mem_rd_addr) === rd_q[0].val)) begin
                    errors++;
                    $display("FAIL rd cyc=%0d got en=%b addr=%h required en=%b addr=%h",
                             cyc, mem_rd_en, mem_rd_addr, ex, ex ? rd_q[0].val : '0);
                end
                if (ex) void'(rd_q.pop_front());
            end

            ex = fd_q.size() > 0 && fd_q[0].cyc == cyc;
            checks++;
            if (feed_valid || ex) begin
                if (!(feed_valid === 1'b1 && ex && feed_data === fd_q[0].val)) begin
                    errors++;
                    $display("FAIL feed cyc=%0d got vld=%b data=%h required vld=%b data=%h",
                             cyc, feed_valid, feed_data, ex, ex ? fd_q[0].val : '0);
                end
                if (ex) void'(fd_q.pop_front());
            end else if (feed_data !== '0) begin
                errors++;
                $display("FAIL feed_zero cyc=%0d got data=%h required 0", cyc, feed_data);
            end

            ex = dn_q.size() > 0 && dn_q[0].cyc == cyc;
            if (done || ex) begin
                checks++;
                if (!(done === 1'b1 && ex)) begin
                    errors++;
                    $display("FAIL done cyc=%0d got %b required %b", cyc, done, ex);
                end
                if (ex) void'(dn_q.pop_front());
            end

            checks++;
            if (busy !== (cyc >= busy_lo && cyc <= busy_hi)) begin
                errors++;
                $display("FAIL busy cyc=%0d got %b required %b", cyc, busy, (cyc >= busy_lo && cyc <= busy_hi));
            end
        end
    end

    task automatic check_outputs_zero(input string nm);
        checks++;
        if ({busy, done, mem_rd_en, feed_valid} !== 4'b0 || feed_data !== '0 || mem_rd_addr !== '0) begin
            errors++;
            $display("FAIL %s got busy=%b done=%b rd_en=%b fv=%b addr=%h data=%h required all 0",
                     nm, busy, done, mem_rd_en, feed_valid, mem_rd_addr, feed_data);
        end
    endtask

    // Issue one start; optionally hold start through the pass or poke start while busy.
    task automatic do_pass(input logic [AW-1:0] b, input int k, input bit hold, input bit poke);
        int s, d, pk;
        @(posedge clk);
        #1;
        start = 1'b1; base_addr = b; num_vecs = CW'(k);
        s = cyc;
        d = model_pass(s, b, k);
        pk = s + 1 + $urandom_range(0, d - s - 1);
        while (cyc <= d) begin
            @(posedge clk);
            #1;
            base_addr = AW'($urandom);
            num_vecs  = CW'($urandom);
            if (hold && cyc <= d) start = 1'b1;
            else                  start = poke && (cyc == pk);
        end
    endtask

    task automatic reset_midpass(input string nm);
        @(posedge clk);
        #2;
        rst = 1'b1;
        rd_q.delete(); fd_q.delete(); dn_q.delete();
        busy_lo = 1; busy_hi = 0;
        #1;
        check_outputs_zero(nm);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    initial begin
        int s, guard;
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
        for (int i = 0; i < PATLEN; i++) stall_pat[i] = 1'b0;
`ifdef FEED_STALL_EN
        for (int i = 1500; i < PATLEN; i++) stall_pat[i] = ($urandom_range(0, 3) == 0);
`endif
        rst = 1'b1; start = 1'b0; base_addr = '0; num_vecs = '0;
        #1;
        check_outputs_zero("reset_state");
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;

        do_pass(8'h10, 3, 1'b0, 1'b0);
        do_pass(8'h20, 0, 1'b0, 1'b0);
        do_pass(8'h30, 2, 1'b1, 1'b0);
        do_pass(8'h40, 1, 1'b0, 1'b1);

        // Wrap-around pass killed by reset two cycles after start, then a clean pass.
        @(posedge clk);
        #1;
        start = 1'b1; base_addr = 8'hFE; num_vecs = 8'd3;
        s = cyc;
        void'(model_pass(s, 8'hFE, 3));
        @(posedge clk);
        #1;
        start = 1'b0;
        reset_midpass("reset_midpass");
        do_pass(8'hFE, 3, 1'b0, 1'b0);

`ifdef FEED_STALL_EN
        s = cyc + 1;
        stall_pat[s + 2] = 1'b1;
        do_pass(8'h10, 3, 1'b0, 1'b0);
`endif

        while (cyc < 1500) @(posedge clk);
        for (int n = 0; n < 40; n++) begin
            do_pass(AW'($urandom), $urandom_range(0, 6), ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        @(posedge clk);
        #1;
        start = 1'b1; base_addr = AW'($urandom); num_vecs = 8'd5;
        s = cyc;
        void'(model_pass(s, base_addr, 5));
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        reset_midpass("reset_random");
        do_pass(8'h00, 4, 1'b0, 1'b0);

        guard = 0;
        while ((rd_q.size() + fd_q.size() + dn_q.size()) > 0 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        repeat (2) @(posedge clk);
        checks++;
        if ((rd_q.size() + fd_q.size() + dn_q.size()) != 0) begin
            errors++;
            $display("FAIL drain_queues got %0d pending events required 0", rd_q.size() + fd_q.size() + dn_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
